// File: rtl/generic_dual_port_ram_clr.sv
// Simple-dual-port RAM with per-lane write mask, selectable read-during-write
// behaviour, optional output register and a built-in clear sweep engine.
module generic_dual_port_ram_clr #(
    parameter int                    DATA_WIDTH    = 16,
    parameter int                    ADDRESS_WIDTH = 8,
    parameter int                    BYTE_WIDTH    = 8,
    parameter int                    RDW_MODE      = 0,
    parameter int                    OUTPUT_REG    = 0,
    parameter logic [DATA_WIDTH-1:0] CLEAR_VALUE   = {DATA_WIDTH{1'b0}}
) (
    input  logic                             clk,
    input  logic                             rst,
    input  logic                             clear_req,
    output logic                             busy,
    input  logic                             wr_en,
    input  logic [ADDRESS_WIDTH-1:0]         wr_addr,
    input  logic [DATA_WIDTH-1:0]            wr_data,
    input  logic [DATA_WIDTH/BYTE_WIDTH-1:0] wr_mask,
    input  logic                             rd_en,
    input  logic [ADDRESS_WIDTH-1:0]         rd_addr,
    output logic [DATA_WIDTH-1:0]            rd_data,
    output logic                             rd_valid
);

    localparam int NB    = DATA_WIDTH / BYTE_WIDTH;
    localparam int DEPTH = 1 << ADDRESS_WIDTH;
    localparam bit USE_NEW_DATA = (RDW_MODE != 32'sd0);
    localparam bit USE_OUT_REG  = (OUTPUT_REG != 32'sd0);
    // clr_addr carries one spare bit so the terminal count never wraps.
    localparam logic [ADDRESS_WIDTH:0] CLR_LAST = {1'b0, {ADDRESS_WIDTH{1'b1}}};
    localparam logic [ADDRESS_WIDTH:0] CLR_ZERO = {(ADDRESS_WIDTH+1){1'b0}};
    localparam logic [ADDRESS_WIDTH:0] CLR_ONE  = {{ADDRESS_WIDTH{1'b0}}, 1'b1};

    typedef enum logic [0:0] {
        ST_IDLE  = 1'b0,
        ST_CLEAR = 1'b1
    } state_t;

    logic [DATA_WIDTH-1:0]    mem_q [0:DEPTH-1];

    state_t                   state_q, state_d;
    logic [ADDRESS_WIDTH:0]   clr_addr_q, clr_addr_d;
    logic                     busy_q, busy_d;
    logic [DATA_WIDTH-1:0]    rd_data1_q, rd_data1_d;
    logic                     rd_valid1_q, rd_valid1_d;
    logic [DATA_WIDTH-1:0]    rd_data2_q, rd_data2_d;
    logic                     rd_valid2_q, rd_valid2_d;

    logic [NB-1:0]            mem_lane_we_s;
    logic [ADDRESS_WIDTH-1:0] mem_addr_s;
    logic [DATA_WIDTH-1:0]    mem_wdata_s;
    logic                     wr_accept_s;
    logic                     rd_accept_s;
    logic                     rdw_hit_s;
    logic [DATA_WIDTH-1:0]    rd_word_s;
    logic [DATA_WIDTH-1:0]    rd_merge_s;

    // Sweep/idle sequencing and arbitration of the single array write port.
    always_comb begin
        state_d       = state_q;
        clr_addr_d    = clr_addr_q;
        mem_lane_we_s = {NB{1'b0}};
        mem_addr_s    = wr_addr;
        mem_wdata_s   = wr_data;
        wr_accept_s   = 1'b0;
        rd_accept_s   = 1'b0;
        case (state_q)
            ST_CLEAR: begin
                mem_lane_we_s = {NB{1'b1}};
                mem_addr_s    = clr_addr_q[ADDRESS_WIDTH-1:0];
                mem_wdata_s   = CLEAR_VALUE;
                if (clr_addr_q == CLR_LAST) begin
                    state_d    = ST_IDLE;
                    clr_addr_d = CLR_ZERO;
                end else begin
                    clr_addr_d = clr_addr_q + CLR_ONE;
                end
            end
            ST_IDLE: begin
                wr_accept_s = wr_en;
                rd_accept_s = rd_en;
                if (wr_en) begin
                    mem_lane_we_s = wr_mask;
                end else begin
                    mem_lane_we_s = {NB{1'b0}};
                end
                if (clear_req) begin
                    state_d    = ST_CLEAR;
                    clr_addr_d = CLR_ZERO;
                end else begin
                    state_d    = ST_IDLE;
                end
            end
            default: begin
                state_d    = ST_CLEAR;
                clr_addr_d = CLR_ZERO;
            end
        endcase
        busy_d = (state_d == ST_CLEAR);
    end

    // Read path: optional same-address bypass, then one or two pipeline stages.
    always_comb begin
        rd_word_s  = mem_q[rd_addr];
        rdw_hit_s  = rd_accept_s && wr_accept_s && (wr_addr == rd_addr);
        rd_merge_s = rd_word_s;
        for (int i = 0; i < NB; i++) begin
            if (USE_NEW_DATA && rdw_hit_s && wr_mask[i]) begin
                rd_merge_s[i*BYTE_WIDTH +: BYTE_WIDTH] = wr_data[i*BYTE_WIDTH +: BYTE_WIDTH];
            end else begin
                rd_merge_s[i*BYTE_WIDTH +: BYTE_WIDTH] = rd_word_s[i*BYTE_WIDTH +: BYTE_WIDTH];
            end
        end
        rd_valid1_d = rd_accept_s;
        if (rd_accept_s) begin
            rd_data1_d = rd_merge_s;
        end else begin
            rd_data1_d = rd_data1_q;
        end
        // The second stage keeps draining during a sweep so in-flight reads complete.
        rd_valid2_d = rd_valid1_q;
        if (rd_valid1_q) begin
            rd_data2_d = rd_data1_q;
        end else begin
            rd_data2_d = rd_data2_q;
        end
    end

    // Array write port; contents are not reset, the sweep initialises them.
    always_ff @(posedge clk) begin
        for (int i = 0; i < NB; i++) begin
            if (mem_lane_we_s[i]) begin
                mem_q[mem_addr_s][i*BYTE_WIDTH +: BYTE_WIDTH] <= mem_wdata_s[i*BYTE_WIDTH +: BYTE_WIDTH];
            end
        end
    end

    // Control state and read pipeline registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= ST_CLEAR;
            clr_addr_q  <= CLR_ZERO;
            busy_q      <= 1'b1;
            rd_data1_q  <= {DATA_WIDTH{1'b0}};
            rd_valid1_q <= 1'b0;
            rd_data2_q  <= {DATA_WIDTH{1'b0}};
            rd_valid2_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            clr_addr_q  <= clr_addr_d;
            busy_q      <= busy_d;
            rd_data1_q  <= rd_data1_d;
            rd_valid1_q <= rd_valid1_d;
            rd_data2_q  <= rd_data2_d;
            rd_valid2_q <= rd_valid2_d;
        end
    end

    assign busy     = busy_q;
    assign rd_data  = USE_OUT_REG ? rd_data2_q  : rd_data1_q;
    assign rd_valid = USE_OUT_REG ? rd_valid2_q : rd_valid1_q;

endmodule

// File: tb/tb_generic_dual_port_ram_clr.sv
// Scoreboard bench: two RAM instances (old-data/1-cycle and new-data/2-cycle with
// a non-zero clear value) driven by one stimulus stream, checked against a model.
module tb_generic_dual_port_ram_clr;

    localparam logic [15:0] CLR1 = 16'h5A5A;

    typedef struct {
        logic [15:0] data;
        int          due;
    } sb_t;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        clear_req = 1'b0;
    logic        wr_en = 1'b0;
    logic [7:0]  wr_addr = 8'h00;
    logic [15:0] wr_data = 16'h0000;
    logic [1:0]  wr_mask = 2'b00;
    logic        rd_en = 1'b0;
    logic [7:0]  rd_addr = 8'h00;

    logic        busy0, busy1, rd_valid0, rd_valid1;
    logic [15:0] rd_data0, rd_data1;

    int          edge_cnt = 0;
    int          n_cmp = 0;
    int          n_bad = 0;
    sb_t         q0[$];
    sb_t         q1[$];
    logic [15:0] mem_m0 [256];
    logic [15:0] mem_m1 [256];

    generic_dual_port_ram_clr #(
        .DATA_WIDTH(16), .ADDRESS_WIDTH(8), .BYTE_WIDTH(8),
        .RDW_MODE(0), .OUTPUT_REG(0), .CLEAR_VALUE(16'h0000)
    ) dut0 (
        .clk(clk), .rst(rst), .clear_req(clear_req), .busy(busy0),
        .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data), .wr_mask(wr_mask),
        .rd_en(rd_en), .rd_addr(rd_addr), .rd_data(rd_data0), .rd_valid(rd_valid0)
    );

    generic_dual_port_ram_clr #(
        .DATA_WIDTH(16), .ADDRESS_WIDTH(8), .BYTE_WIDTH(8),
        .RDW_MODE(1), .OUTPUT_REG(1), .CLEAR_VALUE(CLR1)
    ) dut1 (
        .clk(clk), .rst(rst), .clear_req(clear_req), .busy(busy1),
        .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data), .wr_mask(wr_mask),
        .rd_en(rd_en), .rd_addr(rd_addr), .rd_data(rd_data1), .rd_valid(rd_valid1)
    );

    always #5 clk = ~clk;

    always @(posedge clk) edge_cnt <= edge_cnt + 1;

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, obs, exp, $time);
        end
    endtask

    task automatic sb_observe(input int idx, input logic vld, input logic [15:0] dat);
        sb_t e;
        if (idx == 0) begin
            if (vld) begin
                if (q0.size() == 0) check_eq("unexp_valid0", {31'd0, vld}, 32'd0);
                else begin
                    e = q0.pop_front();
                    check_eq("rd_data0", {16'd0, dat}, {16'd0, e.data});
                    check_eq("rd_lat0", edge_cnt, e.due);
                end
            end else if (q0.size() != 0 && q0[0].due <= edge_cnt) begin
                e = q0.pop_front();
                check_eq("miss_valid0", {31'd0, vld}, 32'd1);
            end
        end else begin
            if (vld) begin
                if (q1.size() == 0) check_eq("unexp_valid1", {31'd0, vld}, 32'd0);
                else begin
                    e = q1.pop_front();
                    check_eq("rd_data1", {16'd0, dat}, {16'd0, e.data});
                    check_eq("rd_lat1", edge_cnt, e.due);
                end
            end else if (q1.size() != 0 && q1[0].due <= edge_cnt) begin
                e = q1.pop_front();
                check_eq("miss_valid1", {31'd0, vld}, 32'd1);
            end
        end
    endtask

    always @(negedge clk) begin
        sb_observe(0, rd_valid0, rd_data0);
        sb_observe(1, rd_valid1, rd_data1);
    end

    // One accepted cycle of stimulus (design must be idle); model and scoreboard updated here.
    task automatic do_op(input logic we, input logic [7:0] wa, input logic [15:0] wd,
                         input logic [1:0] wm, input logic re, input logic [7:0] ra,
                         input logic clr);
        sb_t         e;
        logic [15:0] old0, old1, new1;
        wr_en = we; wr_addr = wa; wr_data = wd; wr_mask = wm;
        rd_en = re; rd_addr = ra; clear_req = clr;
        if (re) begin
            old0 = mem_m0[ra];
            old1 = mem_m1[ra];
            new1 = old1;
            if (we && wa == ra) begin
                if (wm[0]) new1[7:0]  = wd[7:0];
                if (wm[1]) new1[15:8] = wd[15:8];
            end
            e.data = old0; e.due = edge_cnt + 1; q0.push_back(e);
            e.data = new1; e.due = edge_cnt + 2; q1.push_back(e);
        end
        if (we) begin
            if (wm[0]) begin mem_m0[wa][7:0]  = wd[7:0];  mem_m1[wa][7:0]  = wd[7:0];  end
            if (wm[1]) begin mem_m0[wa][15:8] = wd[15:8]; mem_m1[wa][15:8] = wd[15:8]; end
        end
        @(posedge clk); #1;
        wr_en = 1'b0; rd_en = 1'b0; clear_req = 1'b0;
    endtask

    task automatic model_cleared();
        for (int a = 0; a < 256; a++) begin
            mem_m0[a] = 16'h0000;
            mem_m1[a] = CLR1;
        end
    endtask

    task automatic idle_cycles(input int n);
        for (int i = 0; i < n; i++) begin
            @(posedge clk); #1;
        end
    endtask

    // Counts post-edge samples with busy high, bounded so a stuck sweep still terminates.
    task automatic wait_sweep(output int cnt);
        cnt = 0;
        while (busy0 && cnt < 1000) begin
            cnt++;
            @(posedge clk); #1;
        end
    endtask

    initial begin
        int cnt;
        // Reset state
        idle_cycles(3);
        check_eq("rst_busy0", {31'd0, busy0}, 32'd1);
        check_eq("rst_busy1", {31'd0, busy1}, 32'd1);
        check_eq("rst_valid0", {31'd0, rd_valid0}, 32'd0);
        check_eq("rst_data1", {16'd0, rd_data1}, 32'd0);

        // 1. Initial sweep is exactly 256 cycles, then memory reads back as clear value
        rst = 1'b0;
        wait_sweep(cnt);
        check_eq("init_sweep_len", cnt, 256);
        check_eq("busy1_after", {31'd0, busy1}, 32'd0);
        model_cleared();
        do_op(1'b0, 8'h00, 16'h0000, 2'b00, 1'b1, 8'h00, 1'b0);
        do_op(1'b0, 8'h00, 16'h0000, 2'b00, 1'b1, 8'h7F, 1'b0);
        do_op(1'b0, 8'h00, 16'h0000, 2'b00, 1'b1, 8'hFF, 1'b0);
        idle_cycles(3);

        // 2. Byte-masked writes and a zero-mask no-op
        do_op(1'b1, 8'h10, 16'hA5A5, 2'b11, 1'b0, 8'h00, 1'b0);
        do_op(1'b1, 8'h10, 16'h3C00, 2'b10, 1'b0, 8'h00, 1'b0);
        do_op(1'b0, 8'h00, 16'h0000, 2'b00, 1'b1, 8'h10, 1'b0);
        do_op(1'b1, 8'h10, 16'hFFFF, 2'b00, 1'b0, 8'h00, 1'b0);
        do_op(1'b0, 8'h00, 16'h0000, 2'b00, 1'b1, 8'h10, 1'b0);
        idle_cycles(4);
        check_eq("hold_data0", {16'd0, rd_data0}, 32'h3CA5);
        check_eq("hold_data1", {16'd0, rd_data1}, 32'h3CA5);

        // 3. Read-during-write on the same address, full and partial masks
        do_op(1'b1, 8'h20, 16'h1234, 2'b11, 1'b0, 8'h00, 1'b0);
        do_op(1'b1, 8'h20, 16'hBEEF, 2'b11, 1'b1, 8'h20, 1'b0);
        do_op(1'b0, 8'h00, 16'h0000, 2'b00, 1'b1, 8'h20, 1'b0);
        do_op(1'b1, 8'h20, 16'h5600, 2'b10, 1'b1, 8'h20, 1'b0);
        do_op(1'b1, 8'h21, 16'h7777, 2'b11, 1'b1, 8'h20, 1'b0);
        idle_cycles(3);

        // 4. Back-to-back reads at full throughput
        for (int a = 0; a < 4; a++) begin
            do_op(1'b1, 8'(a), 16'hC000 + 16'(a), 2'b11, 1'b0, 8'h00, 1'b0);
        end
        for (int a = 0; a < 4; a++) begin
            do_op(1'b0, 8'h00, 16'h0000, 2'b00, 1'b1, 8'(a), 1'b0);
        end
        idle_cycles(3);

        // 5. Fill, clear with traffic during the sweep and a second ignored request
        for (int a = 0; a < 256; a++) begin
            do_op(1'b1, 8'(a), {8'(a) ^ 8'h3C, 8'(a)}, 2'b11, 1'b0, 8'h00, 1'b0);
        end
        do_op(1'b0, 8'h00, 16'h0000, 2'b00, 1'b1, 8'h80, 1'b0);
        do_op(1'b0, 8'h00, 16'h0000, 2'b00, 1'b1, 8'hFF, 1'b0);
        do_op(1'b1, 8'h07, 16'h7777, 2'b11, 1'b1, 8'h05, 1'b1);
        cnt = 0;
        while (busy0 && cnt < 1000) begin
            cnt++;
            wr_en = 1'b1; wr_addr = 8'($urandom_range(0, 255)); wr_data = 16'hFFFF;
            wr_mask = 2'b11; rd_en = 1'b1; rd_addr = 8'($urandom_range(0, 255));
            clear_req = (cnt == 100);
            @(posedge clk); #1;
        end
        wr_en = 1'b0; rd_en = 1'b0; clear_req = 1'b0;
        check_eq("clr_sweep_len", cnt, 256);
        model_cleared();
        for (int a = 0; a < 256; a++) begin
            do_op(1'b0, 8'h00, 16'h0000, 2'b00, 1'b1, 8'(a), 1'b0);
        end
        idle_cycles(3);

        // 6. Reset in the middle of a sweep restarts it from address 0
        do_op(1'b1, 8'h90, 16'h9999, 2'b11, 1'b0, 8'h00, 1'b0);
        do_op(1'b1, 8'h05, 16'h0505, 2'b11, 1'b0, 8'h00, 1'b0);
        idle_cycles(3);
        do_op(1'b0, 8'h00, 16'h0000, 2'b00, 1'b0, 8'h00, 1'b1);
        idle_cycles(129);
        check_eq("mid_busy0", {31'd0, busy0}, 32'd1);
        rst = 1'b1;
        #1;
        check_eq("rst_mid_busy0", {31'd0, busy0}, 32'd1);
        check_eq("rst_mid_data1", {16'd0, rd_data1}, 32'd0);
        check_eq("rst_mid_valid1", {31'd0, rd_valid1}, 32'd0);
        idle_cycles(3);
        rst = 1'b0;
        wait_sweep(cnt);
        check_eq("restart_sweep_len", cnt, 256);
        model_cleared();
        do_op(1'b0, 8'h00, 16'h0000, 2'b00, 1'b1, 8'h90, 1'b0);
        do_op(1'b0, 8'h00, 16'h0000, 2'b00, 1'b1, 8'h05, 1'b0);
        do_op(1'b0, 8'h00, 16'h0000, 2'b00, 1'b1, 8'h00, 1'b0);
        do_op(1'b0, 8'h00, 16'h0000, 2'b00, 1'b1, 8'hFF, 1'b0);
        idle_cycles(4);

        check_eq("sb_drain0", q0.size(), 0);
        check_eq("sb_drain1", q1.size(), 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
